vga_ram_writer: RTL and testbench
=================================

# vga_ram_writer

Producer-side writer for the VGA frame-buffer RAM: turns the PPU's raster-ordered pixel stream into write-port traffic (`wraddress`/`data`/`wren`) for the dual-port VGA RAM. The RAM's read port is scanned independently by the VGA RAM reader. The block also provides a bulk clear that fills the visible buffer with a fixed palette index. It sits between the PPU pixel output and the RAM write port, in the same clock domain as the RAM write clock.

## Interface
- WIDTH, 256, active pixels per line
- HEIGHT, 240, active lines per frame
- ADDR_W, 16, RAM address width; WIDTH*HEIGHT ≤ 2^ADDR_W
- DATA_W, 6, palette-index width
- CLEAR_COLOR, 6'h0F, index written by bulk clear

Ports:
- clk  in  1  single clock; RAM write clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse; next accepted pixel is (0,0)
- pixel_valid  in  1  pixel_data valid this cycle
- pixel_data  in  DATA_W  palette index
- clear_req  in  1  one-cycle pulse; request bulk clear
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  DATA_W  RAM write data
- wren  out  1  RAM write enable
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse, frame fully written
- clear_done  out  1  one-cycle pulse, clear finished
- overrun  out  1  sticky; pixel_valid arrived while not accepting pixels

## Operation
- Linear address counter `addr`, plus x (0..WIDTH-1) and y (0..HEIGHT-1) counters. Each write targets `addr = y*WIDTH + x`; `addr` increments by 1 per write.
- States: IDLE, ACTIVE, CLEAR. Pending flags: `pend_clear`, `pend_start`.
- IDLE:
  - clear_req or pend_clear → CLEAR, counters zeroed.
  - Otherwise, frame_start or pend_start → ACTIVE, counters zeroed.
  - clear has priority when both arrive together; the start is kept in pend_start.
  - pixel_valid is dropped and sets overrun.
- ACTIVE:
  - Each pixel_valid writes pixel_data at addr, then advances x, wraps x to 0 and increments y at WIDTH-1.
  - The write of (WIDTH-1, HEIGHT-1) generates frame_done and transitions to IDLE.
  - frame_start in ACTIVE abandons the partial frame and zeroes counters. pixel_valid in the same cycle is written as pixel (0,0).
  - clear_req in ACTIVE sets pend_clear; it is serviced on return to IDLE.
- CLEAR:
  - Writes CLEAR_COLOR to addresses 0..WIDTH*HEIGHT-1, one per cycle, wren continuously high.
  - After the last address, generates clear_done and transitions to IDLE.
  - frame_start sets pend_start.
  - clear_req is ignored because a clear is already running.
  - pixel_valid is dropped and sets overrun.
- Pending flags are cleared when serviced.
- overrun is cleared only by rst.
- Addresses ≥ WIDTH*HEIGHT are never written.

## Timing
- All outputs are registered.
- Reset values: wr_addr=0, wr_data=0, wren=0, busy=0, frame_done=0, clear_done=0, overrun=0, state=IDLE, pending flags=0.
- Write latency is 1 cycle. pixel_valid in cycle N produces wren=1 with wr_addr and wr_data in cycle N+1. wren is 0 in any cycle with no write.
- frame_done rises in the same cycle as the wren of the final pixel.
- clear_done rises in the same cycle as the wren of the final clear address.
- busy goes high the cycle after the accepting frame_start or clear_req. It goes low the cycle after the final write.
- A pending start or pending clear is entered in the cycle after the block returns to IDLE. This gives one idle gap cycle.
- Clear takes exactly WIDTH*HEIGHT cycles of wren (61440 at defaults).
- rst asserted mid-operation immediately forces the reset values. No partial write completes after rst.
- Throughput: one pixel per cycle sustained. pixel_valid may be held high continuously.

## Test plan
- Reset, frame_start, then 61440 back-to-back pixels with data=i[5:0] -> wren every cycle, wr_addr 0x0000..0xEFFF, wr_data matches, frame_done exactly with addr 0xEFFF, busy low next cycle, overrun=0.
- clear_req in IDLE -> 61440 writes of 0x0F to 0x0000..0xEFFF, clear_done on the last write, then no wren.
- frame_start after 300 pixels, with pixel_valid=1 (data 0x21) in the same cycle -> next write is addr 0x0000 data 0x21, and the frame completes at 0xEFFF.
- clear_req during ACTIVE at pixel 1000 -> frame finishes normally (frame_done), 1 idle cycle, then the full clear runs. frame_start during CLEAR -> ACTIVE entered 1 cycle after clear_done.
- pixel_valid in IDLE, and pixel_valid during CLEAR -> no extra wren, overrun=1 and stays 1 through a later complete frame.
- rst asserted mid-clear at addr 0x1234 -> all outputs at reset values the same cycle. After release, frame_start starts writing at 0x0000.

Source files
------------

// File: rtl/vga_ram_writer.sv
// Frame-buffer write-port driver: turns the PPU raster pixel stream into RAM writes
// and provides a bulk clear of the visible buffer to a fixed palette index.
module vga_ram_writer #(
    parameter int                 WIDTH       = 256,
    parameter int                 HEIGHT      = 240,
    parameter int                 ADDR_W      = 16,
    parameter int                 DATA_W      = 6,
    parameter logic [DATA_W-1:0]  CLEAR_COLOR = 'h0F
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame_start,
    input  logic              i_pixel_valid,
    input  logic [DATA_W-1:0] i_pixel_data,
    input  logic              i_clear_req,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wren,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_clear_done,
    output logic              o_overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] X_LAST    = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] Y_LAST    = ADDR_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    state_t            r_state,      w_state_nxt;
    logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
    logic [ADDR_W-1:0] r_x,          w_x_nxt;
    logic [ADDR_W-1:0] r_y,          w_y_nxt;
    logic              r_pend_clear, w_pend_clear_nxt;
    logic              r_pend_start, w_pend_start_nxt;
    logic [ADDR_W-1:0] r_wr_addr,    w_wr_addr_nxt;
    logic [DATA_W-1:0] r_wr_data,    w_wr_data_nxt;
    logic              r_wren,       w_wren_nxt;
    logic              r_frame_done, w_frame_done_nxt;
    logic              r_clear_done, w_clear_done_nxt;
    logic              r_overrun,    w_overrun_nxt;
    logic              r_busy;
    logic [ADDR_W-1:0] w_base_addr, w_base_x, w_base_y;

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_pend_clear_nxt = r_pend_clear;
        w_pend_start_nxt = r_pend_start;
        w_wr_addr_nxt    = r_wr_addr;
        w_wr_data_nxt    = r_wr_data;
        w_wren_nxt       = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_clear_done_nxt = 1'b0;
        w_overrun_nxt    = r_overrun;
        // A restart in ACTIVE rebases the raster so a same-cycle pixel lands at (0,0)
        w_base_addr      = i_frame_start ? '0 : r_addr;
        w_base_x         = i_frame_start ? '0 : r_x;
        w_base_y         = i_frame_start ? '0 : r_y;

        case (r_state)
            IDLE: begin
                if (i_pixel_valid)
                    w_overrun_nxt = 1'b1;
                if (i_clear_req || r_pend_clear) begin
                    w_state_nxt      = CLEAR;
                    w_addr_nxt       = '0;
                    w_x_nxt          = '0;
                    w_y_nxt          = '0;
                    w_pend_clear_nxt = 1'b0;
                    w_pend_start_nxt = r_pend_start | i_frame_start;
                end else if (i_frame_start || r_pend_start) begin
                    w_state_nxt      = ACTIVE;
                    w_addr_nxt       = '0;
                    w_x_nxt          = '0;
                    w_y_nxt          = '0;
                    w_pend_start_nxt = 1'b0;
                end
            end
            ACTIVE: begin
                if (i_clear_req)
                    w_pend_clear_nxt = 1'b1;
                w_addr_nxt = w_base_addr;
                w_x_nxt    = w_base_x;
                w_y_nxt    = w_base_y;
                if (i_pixel_valid) begin
                    w_wren_nxt    = 1'b1;
                    w_wr_addr_nxt = w_base_addr;
                    w_wr_data_nxt = i_pixel_data;
                    w_addr_nxt    = w_base_addr + 1'b1;
                    if (w_base_x == X_LAST) begin
                        w_x_nxt = '0;
                        w_y_nxt = w_base_y + 1'b1;
                        if (w_base_y == Y_LAST) begin
                            w_frame_done_nxt = 1'b1;
                            w_state_nxt      = IDLE;
                        end
                    end else begin
                        w_x_nxt = w_base_x + 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (i_pixel_valid)
                    w_overrun_nxt = 1'b1;
                if (i_frame_start)
                    w_pend_start_nxt = 1'b1;
                w_wren_nxt    = 1'b1;
                w_wr_addr_nxt = r_addr;
                w_wr_data_nxt = CLEAR_COLOR;
                w_addr_nxt    = r_addr + 1'b1;
                if (r_addr == LAST_ADDR) begin
                    w_clear_done_nxt = 1'b1;
                    w_state_nxt      = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_pend_clear <= 1'b0;
            r_pend_start <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wren       <= 1'b0;
            r_frame_done <= 1'b0;
            r_clear_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_pend_clear <= w_pend_clear_nxt;
            r_pend_start <= w_pend_start_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_wren       <= w_wren_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_clear_done <= w_clear_done_nxt;
            r_overrun    <= w_overrun_nxt;
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_wren       = r_wren;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_clear_done = r_clear_done;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_vga_ram_writer.sv
// Directed bench for vga_ram_writer on a reduced 8x4 raster (32 pixels, last address 0x1F).
module tb_vga_ram_writer;

    localparam int W      = 8;
    localparam int H      = 4;
    localparam int TOTAL  = W * H;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 6;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_frame_start = 1'b0;
    logic              i_pixel_valid = 1'b0;
    logic [DATA_W-1:0] i_pixel_data  = '0;
    logic              i_clear_req   = 1'b0;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_wren, o_busy, o_frame_done, o_clear_done, o_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    vga_ram_writer #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_COLOR(6'h0F)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start),
        .i_pixel_valid(i_pixel_valid), .i_pixel_data(i_pixel_data),
        .i_clear_req(i_clear_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_wren(o_wren), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_clear_done(o_clear_done), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_frame_start = 1'b0; i_pixel_valid = 1'b0;
        i_clear_req = 1'b0; i_pixel_data = '0;
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        step();
        n_checks++; if (o_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", o_wren); end
        n_checks++; if (o_wr_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", o_wr_addr); end
        n_checks++; if (o_wr_data !== 6'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_wr_data); end
        n_checks++; if ({o_busy, o_frame_done, o_clear_done, o_overrun} !== 4'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {o_busy, o_frame_done, o_clear_done, o_overrun}); end
        i_rst = 1'b0;
    endtask

    task automatic test_frame();
        do_reset();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        n_checks++; if ({o_busy, o_wren} !== 2'b10) begin n_fail++; $display("FAIL frame_start_busy: got busy=%b wren=%b want 1/0", o_busy, o_wren); end
        for (int i = 0; i < TOTAL; i++) begin
            i_pixel_valid = 1'b1;
            i_pixel_data  = 6'(i);
            step();
            n_checks++; if ({o_wren, o_wr_addr, o_wr_data} !== {1'b1, 16'(i), 6'(i)})
                begin n_fail++; $display("FAIL frame_write[%0d]: got wren=%b addr=%h data=%h want 1/%h/%h", i, o_wren, o_wr_addr, o_wr_data, 16'(i), 6'(i)); end
            n_checks++; if (o_frame_done !== (i == TOTAL - 1))
                begin n_fail++; $display("FAIL frame_done[%0d]: got %b want %b", i, o_frame_done, (i == TOTAL - 1)); end
        end
        i_pixel_valid = 1'b0;
        step();
        n_checks++; if ({o_busy, o_wren, o_frame_done, o_overrun} !== 4'b0)
            begin n_fail++; $display("FAIL frame_after: got busy/wren/done/ovr=%b want 0000", {o_busy, o_wren, o_frame_done, o_overrun}); end
    endtask

    task automatic test_clear();
        do_reset();
        i_clear_req = 1'b1;
        step();
        i_clear_req = 1'b0;
        n_checks++; if ({o_busy, o_wren} !== 2'b10) begin n_fail++; $display("FAIL clear_accept: got busy=%b wren=%b want 1/0", o_busy, o_wren); end
        for (int i = 0; i < TOTAL; i++) begin
            step();
            n_checks++; if ({o_wren, o_wr_addr, o_wr_data} !== {1'b1, 16'(i), 6'h0F})
                begin n_fail++; $display("FAIL clear_write[%0d]: got wren=%b addr=%h data=%h want 1/%h/0f", i, o_wren, o_wr_addr, o_wr_data, 16'(i)); end
            n_checks++; if (o_clear_done !== (i == TOTAL - 1))
                begin n_fail++; $display("FAIL clear_done[%0d]: got %b want %b", i, o_clear_done, (i == TOTAL - 1)); end
        end
        step();
        n_checks++; if ({o_wren, o_busy, o_clear_done} !== 3'b0)
            begin n_fail++; $display("FAIL clear_after: got wren/busy/done=%b want 000", {o_wren, o_busy, o_clear_done}); end
    endtask

    task automatic test_restart();
        do_reset();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_pixel_valid = 1'b1; i_pixel_data = 6'(i + 16);
            step();
        end
        i_frame_start = 1'b1; i_pixel_data = 6'h21;
        step();
        i_frame_start = 1'b0;
        n_checks++; if ({o_wren, o_wr_addr, o_wr_data} !== {1'b1, 16'h0, 6'h21})
            begin n_fail++; $display("FAIL restart_first: got wren=%b addr=%h data=%h want 1/0000/21", o_wren, o_wr_addr, o_wr_data); end
        for (int i = 1; i < TOTAL; i++) begin
            i_pixel_data = 6'(i + 32);
            step();
            n_checks++; if ({o_wren, o_wr_addr, o_wr_data, o_frame_done} !== {1'b1, 16'(i), 6'(i + 32), (i == TOTAL - 1)})
                begin n_fail++; $display("FAIL restart_write[%0d]: got wren=%b addr=%h data=%h done=%b", i, o_wren, o_wr_addr, o_wr_data, o_frame_done); end
        end
        i_pixel_valid = 1'b0;
        step();
        n_checks++; if ({o_busy, o_overrun} !== 2'b00) begin n_fail++; $display("FAIL restart_after: got busy=%b ovr=%b want 0/0", o_busy, o_overrun); end
    endtask

    task automatic test_pending();
        do_reset();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            i_pixel_valid = 1'b1; i_pixel_data = 6'(i); i_clear_req = (i == 3);
            step();
        end
        i_pixel_valid = 1'b0; i_clear_req = 1'b0;
        n_checks++; if ({o_frame_done, o_wr_addr, o_busy} !== {1'b1, 16'(TOTAL - 1), 1'b0})
            begin n_fail++; $display("FAIL pend_frame_done: got done=%b addr=%h busy=%b want 1/%h/0", o_frame_done, o_wr_addr, o_busy, 16'(TOTAL - 1)); end
        step();
        n_checks++; if ({o_busy, o_wren} !== 2'b10) begin n_fail++; $display("FAIL pend_gap: got busy=%b wren=%b want 1/0", o_busy, o_wren); end
        for (int i = 0; i < TOTAL; i++) begin
            i_frame_start = (i == 2);
            step();
            n_checks++; if ({o_wren, o_wr_addr, o_wr_data, o_clear_done} !== {1'b1, 16'(i), 6'h0F, (i == TOTAL - 1)})
                begin n_fail++; $display("FAIL pend_clear[%0d]: got wren=%b addr=%h data=%h done=%b", i, o_wren, o_wr_addr, o_wr_data, o_clear_done); end
        end
        i_frame_start = 1'b0;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL pend_clear_end_busy: got %b want 0", o_busy); end
        step();
        n_checks++; if ({o_busy, o_wren} !== 2'b10) begin n_fail++; $display("FAIL pend_start_entry: got busy=%b wren=%b want 1/0", o_busy, o_wren); end
        i_pixel_valid = 1'b1; i_pixel_data = 6'h05;
        step();
        i_pixel_valid = 1'b0;
        n_checks++; if ({o_wren, o_wr_addr, o_wr_data} !== {1'b1, 16'h0, 6'h05})
            begin n_fail++; $display("FAIL pend_start_write: got wren=%b addr=%h data=%h want 1/0000/05", o_wren, o_wr_addr, o_wr_data); end
    endtask

    task automatic test_overrun();
        do_reset();
        i_pixel_valid = 1'b1; i_pixel_data = 6'h3F;
        step();
        i_pixel_valid = 1'b0;
        n_checks++; if ({o_wren, o_overrun} !== 2'b01) begin n_fail++; $display("FAIL ovr_idle: got wren=%b ovr=%b want 0/1", o_wren, o_overrun); end
        i_clear_req = 1'b1;
        step();
        i_clear_req = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            i_pixel_valid = (i < 3);
            step();
            n_checks++; if ({o_wren, o_wr_addr, o_wr_data} !== {1'b1, 16'(i), 6'h0F})
                begin n_fail++; $display("FAIL ovr_clear[%0d]: got wren=%b addr=%h data=%h", i, o_wren, o_wr_addr, o_wr_data); end
        end
        i_pixel_valid = 1'b0;
        step();
        n_checks++; if (o_wren !== 1'b0) begin n_fail++; $display("FAIL ovr_extra_wren: got %b want 0", o_wren); end
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            i_pixel_valid = 1'b1; i_pixel_data = 6'(i);
            step();
        end
        i_pixel_valid = 1'b0;
        n_checks++; if ({o_frame_done, o_overrun} !== 2'b11) begin n_fail++; $display("FAIL ovr_sticky: got done=%b ovr=%b want 1/1", o_frame_done, o_overrun); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        i_clear_req = 1'b1;
        step();
        i_clear_req = 1'b0;
        for (int i = 0; i <= 18; i++) step();
        n_checks++; if ({o_wren, o_wr_addr} !== {1'b1, 16'h0012}) begin n_fail++; $display("FAIL rst_mid_pre: got wren=%b addr=%h want 1/0012", o_wren, o_wr_addr); end
        i_rst = 1'b1;
        #2;
        n_checks++; if ({o_wren, o_wr_addr, o_wr_data, o_busy, o_frame_done, o_clear_done, o_overrun} !== '0)
            begin n_fail++; $display("FAIL rst_mid_force: got wren=%b addr=%h data=%h busy=%b ovr=%b want all 0", o_wren, o_wr_addr, o_wr_data, o_busy, o_overrun); end
        step();
        i_rst = 1'b0;
        step();
        n_checks++; if ({o_wren, o_busy} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_idle: got wren=%b busy=%b want 0/0", o_wren, o_busy); end
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        i_pixel_valid = 1'b1; i_pixel_data = 6'h07;
        step();
        i_pixel_valid = 1'b0;
        n_checks++; if ({o_wren, o_wr_addr, o_wr_data, o_busy} !== {1'b1, 16'h0, 6'h07, 1'b1})
            begin n_fail++; $display("FAIL rst_mid_restart: got wren=%b addr=%h data=%h busy=%b want 1/0000/07/1", o_wren, o_wr_addr, o_wr_data, o_busy); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_clear();
        test_restart();
        test_pending();
        test_overrun();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
